// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one SPI A2D converter among four requesters.
// One conversion is outstanding at a time, and a watchdog abandons a conversion that never completes.
module a2d_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TO_W    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] chnnl_req,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [11:0] res_out,
  output logic        err,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res
);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_gnt, r_done;
  logic [11:0]       r_res_out;
  logic              r_err;
  logic [2:0]        r_chnnl;
  logic [TO_W-1:0]   r_cnt;
  logic [1:0]        r_last;

  logic [3:0]        w_elig;
  logic              w_found;
  logic [1:0]        w_win;
  logic [1:0]        w_idx;
  logic [2:0]        w_chsel;
  logic              w_tout;

  assign w_tout = (r_cnt == TO_LAST);

  // A requester that is pulsing done this cycle is masked, so it cannot be re-granted immediately.
  always_comb begin
    w_elig  = req & ~r_done;
    w_found = 1'b0;
    w_win   = r_last;
    w_idx   = r_last;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    case (w_win)
      2'd0:    w_chsel = chnnl_req[2:0];
      2'd1:    w_chsel = chnnl_req[5:3];
      2'd2:    w_chsel = chnnl_req[8:6];
      default: w_chsel = chnnl_req[11:9];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = START;
      START:   w_state_nxt = BUSY;
      BUSY:    if (cnv_cmplt || w_tout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_res_out <= '0;
      r_err     <= 1'b0;
      r_chnnl   <= '0;
      r_cnt     <= '0;
      r_last    <= 2'd3;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt   <= 4'b0001 << w_win;
            r_last  <= w_win;
            r_chnnl <= w_chsel;
          end
        end
        START: r_cnt <= '0;
        BUSY: begin
          r_cnt <= r_cnt + CNT_ONE;
          // Completion takes precedence over a coincident timeout.
          if (cnv_cmplt) begin
            r_res_out <= res;
            r_done    <= r_gnt;
            r_gnt     <= '0;
          end else if (w_tout) begin
            r_done <= r_gnt;
            r_err  <= 1'b1;
            r_gnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign res_out  = r_res_out;
  assign err      = r_err;
  assign chnnl    = r_chnnl;
  assign strt_cnv = (r_state == START);

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed self-checking bench for a2d_arbiter; inputs change and outputs are checked on the falling edge.
module tb_a2d_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] chnnl_req;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [11:0] res_out;
  logic        err;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  int n_checks = 0;
  int n_errors = 0;

  a2d_arbiter #(.TIMEOUT(48), .TO_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .chnnl_req(chnnl_req),
    .gnt(gnt), .done(done), .res_out(res_out), .err(err),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    cnv_cmplt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait lat falling edges, then pulse cnv_cmplt for one cycle; returns on the edge where done is visible.
  task automatic convert(input int lat, input logic [11:0] r);
    repeat (lat) @(negedge clk);
    cnv_cmplt = 1'b1;
    res = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res = '0;
  endtask

  initial begin
    logic [3:0] e;
    rst_n = 1'b0; req = '0; chnnl_req = '0; cnv_cmplt = 1'b0; res = '0;

    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_res_out", 32'(res_out), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_chnnl", 32'(chnnl), 32'h0);
    chk("rst_strt", 32'(strt_cnv), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'h0);

    // single requester
    chnnl_req = 12'h140;
    req = 4'b0100;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_strt", 32'(strt_cnv), 32'h1);
    chk("t1_chnnl", 32'(chnnl), 32'h5);
    @(negedge clk);
    chk("t1_strt_once", 32'(strt_cnv), 32'h0);
    chk("t1_gnt_held", 32'(gnt), 32'h4);
    convert(38, 12'hA5C);
    req = '0;
    chk("t1_done", 32'(done), 32'h4);
    chk("t1_res", 32'(res_out), 32'hA5C);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_gnt_clr", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_res_hold", 32'(res_out), 32'hA5C);

    // round robin
    do_reset();
    chnnl_req = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e = 4'(1 << (i % 4));
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(e));
      chk("rr_chnnl", 32'(chnnl), 32'(i % 4));
      chk("rr_strt", 32'(strt_cnv), 32'h1);
      convert(3, 12'(12'h100 + i));
      chk("rr_done", 32'(done), 32'(e));
      chk("rr_res", 32'(res_out), 32'(12'h100 + i));
      chk("rr_gnt_clr", 32'(gnt), 32'h0);
    end
    req = '0;
    @(negedge clk);
    chk("rr_quiet", 32'(gnt), 32'h0);

    // done mask and turnaround
    do_reset();
    chnnl_req = '0;
    req = 4'b0010;
    @(negedge clk);
    chk("dm_gnt1", 32'(gnt), 32'h2);
    convert(2, 12'h211);
    chk("dm_done1", 32'(done), 32'h2);
    @(negedge clk);
    chk("dm_gap", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("dm_regrant", 32'(gnt), 32'h2);
    req = 4'b0011;
    convert(2, 12'h212);
    chk("dm_done1b", 32'(done), 32'h2);
    @(negedge clk);
    chk("dm_turn_gnt0", 32'(gnt), 32'h1);
    chk("dm_turn_done", 32'(done), 32'h0);
    convert(2, 12'h213);
    chk("dm_done0", 32'(done), 32'h1);
    req = '0;
    @(negedge clk);
    chk("dm_quiet", 32'(gnt), 32'h0);

    // timeout
    chnnl_req = 12'h600;
    req = 4'b1000;
    @(negedge clk);
    chk("to_gnt", 32'(gnt), 32'h8);
    chk("to_chnnl", 32'(chnnl), 32'h3);
    repeat (48) @(negedge clk);
    chk("to_early_done", 32'(done), 32'h0);
    chk("to_early_gnt", 32'(gnt), 32'h8);
    @(negedge clk);
    chk("to_done", 32'(done), 32'h8);
    chk("to_err", 32'(err), 32'h1);
    chk("to_res_keep", 32'(res_out), 32'h213);
    chk("to_gnt_clr", 32'(gnt), 32'h0);
    req = '0;
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 32'h0);
    chk("to_done_pulse", 32'(done), 32'h0);
    chnnl_req = 12'h004;
    req = 4'b0001;
    @(negedge clk);
    chk("to_next_gnt", 32'(gnt), 32'h1);
    chk("to_next_chnnl", 32'(chnnl), 32'h4);
    convert(4, 12'h0FF);
    chk("to_next_done", 32'(done), 32'h1);
    chk("to_next_err", 32'(err), 32'h0);
    chk("to_next_res", 32'(res_out), 32'h0FF);
    req = '0;

    // ignored inputs
    @(negedge clk);
    cnv_cmplt = 1'b1;
    res = 12'hBAD;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("ig_idle_done", 32'(done), 32'h0);
    chk("ig_idle_gnt", 32'(gnt), 32'h0);
    chk("ig_idle_res", 32'(res_out), 32'h0FF);
    chnnl_req = 12'h180;
    req = 4'b0100;
    @(negedge clk);
    chk("ig_gnt", 32'(gnt), 32'h4);
    chk("ig_chnnl", 32'(chnnl), 32'h6);
    cnv_cmplt = 1'b1;
    res = 12'h777;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("ig_start_cmplt", 32'(done), 32'h0);
    chk("ig_start_gnt", 32'(gnt), 32'h4);
    req = '0;
    chnnl_req = 12'hFFF;
    @(negedge clk);
    chk("ig_chnnl_hold", 32'(chnnl), 32'h6);
    chk("ig_gnt_hold", 32'(gnt), 32'h4);
    convert(3, 12'h3C3);
    chk("ig_done", 32'(done), 32'h4);
    chk("ig_res", 32'(res_out), 32'h3C3);
    @(negedge clk);
    chk("ig_done_once", 32'(done), 32'h0);
    chk("ig_no_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("ig_still_quiet", 32'(done | gnt), 32'h0);

    // reset mid-BUSY
    req = 4'b1000;
    @(negedge clk);
    chk("rb_gnt", 32'(gnt), 32'h8);
    chk("rb_chnnl", 32'(chnnl), 32'h7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rb_gnt0", 32'(gnt), 32'h0);
    chk("rb_done0", 32'(done), 32'h0);
    chk("rb_res0", 32'(res_out), 32'h0);
    chk("rb_err0", 32'(err), 32'h0);
    chk("rb_chnnl0", 32'(chnnl), 32'h0);
    chk("rb_strt0", 32'(strt_cnv), 32'h0);
    cnv_cmplt = 1'b1;
    res = 12'h001;
    @(negedge clk);
    chk("rb_no_done", 32'(done), 32'h0);
    cnv_cmplt = 1'b0;
    req = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rb_first_gnt", 32'(gnt), 32'h1);
    chk("rb_first_done", 32'(done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
